// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard tracker. Holds the write masks of the DEPTH youngest
//   in-flight instructions (entry 0 = EX ... entry DEPTH-1 = WB) and decides
//   combinationally whether the decoded instruction may issue this cycle.
//
//   Build option: define HAZARD_SCOREBOARD_FWD_EN to assume a full forwarding
//   network. Only loads younger than LOAD_READY then stall a dependent
//   reader, and fwd_hit reports the forwarding source entries. Without it,
//   any hit outside WB stalls and fwd_hit is tied to zero.
//
//   Ports
//     clk, resetn   clock, synchronous active-low reset
//     id_valid      decode holds a valid instruction
//     id_rmask      registers read by decode (bit i = register i+1)
//     id_wmask      registers written by decode
//     id_is_load    decoded instruction is a load
//     advance       back-end advances; 0 freezes all entries
//     flush         kill decode and the flush_depth youngest entries
//     flush_depth   entries to kill, counted after this cycle's shift
//     id_ready      decode may issue (combinational)
//     fwd_hit       per-entry forwarding source flags (combinational)
//     pending       OR of write masks of all valid entries

// Per-entry hit/stall evaluation. Each entry sees only the writes of the
// entries younger than itself (shadow_i), so an older writer of a register
// is hidden whenever a younger writer of the same register is in flight.
module hazard_scoreboard_entry #(
    parameter int MW         = 31,
    parameter int IDX        = 0,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter bit FWD        = 1'b0
) (
    input  logic          vld_i,
    input  logic [MW-1:0] wmask_i,
    input  logic          is_load_i,
    input  logic [MW-1:0] shadow_i,
    input  logic [MW-1:0] rmask_i,
    output logic          block_o,
    output logic          fwd_o,
    output logic [MW-1:0] shadow_o
);
    logic [MW-1:0] eff;
    logic          hit;

    assign eff      = wmask_i & ~shadow_i;
    assign hit      = vld_i & (|(rmask_i & eff));
    // WB never stalls: the register file writes before it is read.
    assign block_o  = hit & (FWD ? (is_load_i & (IDX < LOAD_READY))
                                 : (IDX < DEPTH - 1));
    assign fwd_o    = FWD ? (hit & ~block_o) : 1'b0;
    assign shadow_o = shadow_i | (vld_i ? wmask_i : '0);
endmodule

module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       id_valid,
    input  logic [NREG-2:0]            id_rmask,
    input  logic [NREG-2:0]            id_wmask,
    input  logic                       id_is_load,
    input  logic                       advance,
    input  logic                       flush,
    input  logic [$clog2(DEPTH+1)-1:0] flush_depth,
    output logic                       id_ready,
    output logic [DEPTH-1:0]           fwd_hit,
    output logic [NREG-2:0]            pending
);
    localparam int MW = NREG - 1;
    localparam int IW = $clog2(DEPTH + 1);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0]         ld_q, ld_d;
    logic [DEPTH-1:0][MW-1:0] wm_q, wm_d;

    logic [DEPTH:0][MW-1:0]   shadow;
    logic [DEPTH-1:0]         block;
    logic                     issue;

    assign shadow[0] = '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        hazard_scoreboard_entry #(
            .MW(MW), .IDX(k), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FWD(FWD)
        ) u_ent (
            .vld_i    (vld_q[k]),
            .wmask_i  (wm_q[k]),
            .is_load_i(ld_q[k]),
            .shadow_i (shadow[k]),
            .rmask_i  (id_rmask),
            .block_o  (block[k]),
            .fwd_o    (fwd_hit[k]),
            .shadow_o (shadow[k+1])
        );
    end

    // Readiness deliberately ignores id_valid so decode can use it early.
    assign id_ready = advance & ~(|block);
    assign issue    = id_valid & id_ready & ~flush;

    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        wm_d  = wm_q;
        if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                wm_d[k]  = wm_q[k-1];
            end
            vld_d[0] = issue;
            ld_d[0]  = issue & id_is_load;
            wm_d[0]  = issue ? id_wmask : '0;
        end
        // Flush acts on the post-shift picture; masks are zeroed so that
        // invalid entries never contribute anything.
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (IW'(k) < flush_depth) begin
                    vld_d[k] = 1'b0;
                    ld_d[k]  = 1'b0;
                    wm_d[k]  = '0;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++)
            if (vld_q[k]) pending = pending | wm_q[k];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            ld_q  <= '0;
            wm_q  <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            wm_q  <= wm_d;
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage read/write mask logic.
- Takes per-instruction read and write register masks plus a load flag from decode.
- Tracks in-flight writers in a DEPTH-entry shift register and decides whether the decoded instruction may issue, given forwarding and load-use latency.
- Sits between decode and the EX/MEM/WB back-end. Drives the decode stall, and reports which in-flight entries will forward to the issuing instruction.

Parameters:
NREG, 32, architectural register count; r0 is never tracked, so masks are NREG-1 bits and bit i means register i+1.
DEPTH, 3, in-flight stages tracked after decode (entry 0 = EX, ..., entry DEPTH-1 = WB).
LOAD_READY, 1, a load in entry k blocks a dependent reader while k < LOAD_READY; range 0..DEPTH-1.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_rmask  in  NREG-1  registers read by the decoded instruction
id_wmask  in  NREG-1  registers written by the decoded instruction (includes ra for JAL)
id_is_load  in  1  decoded instruction is a load
advance  in  1  back-end advances this cycle; 0 freezes all entries
flush  in  1  kill the decode instruction and the youngest in-flight entries
flush_depth  in  $clog2(DEPTH+1)  number of youngest entries, counted after this cycle's shift, to kill on flush
id_ready  out  1  decoded instruction may issue this cycle (combinational)
fwd_hit  out  DEPTH  entry k supplies at least one operand of the decode instruction (combinational)
pending  out  NREG-1  OR of the write masks of all valid entries (registered state view)

Behaviour:
- State: entries 0..DEPTH-1, each holding {valid, wmask, is_load}.
- Reset (resetn=0 at posedge): all entries invalid with zero masks. Consequently pending=0, fwd_hit=0 and id_ready=advance. Reset mid-operation discards all in-flight state at once.
- Youngest-writer masking: eff_k = wmask_k & ~(wmask_0 | ... | wmask_{k-1}), using valid entries only. An older writer is shadowed by any younger writer of the same register.
- hit_k = valid_k & |(id_rmask & eff_k). Then fwd_hit[k] = hit_k & ~block_k.
- block_k:
  - with the feature: hit_k & is_load_k & (k < LOAD_READY);
  - without the feature: hit_k & (k < DEPTH-1).
- Entry DEPTH-1 never blocks: the register file is write-before-read.
- id_ready = advance & ~|block. The value is independent of id_valid.
- issue = id_valid & id_ready & ~flush.
- Posedge with advance=1:
  - entries shift, entry k+1 <= entry k, and entry DEPTH-1 retires;
  - entry 0 <= issue ? {1, id_wmask, id_is_load} : invalid (a bubble).
- Posedge with advance=0: entries hold.
- Flush: applied after the shift/hold. Entries 0..flush_depth-1 become invalid. flush_depth > DEPTH clears all entries. flush with advance=0 still clears entries.
- id_wmask = 0 issues a valid entry that never hits (store, branch).
- A read of r0 is impossible by construction of the masks.
- Latency: hazard decision is same-cycle combinational. A newly issued writer is visible one cycle later.
- Width rules: masks are exactly NREG-1 bits. Internal index arithmetic uses $clog2(DEPTH+1) bits.

Optional Feature:
Macro HAZARD_SCOREBOARD_FWD_EN.
- Defined: full forwarding network assumed. Only loads with k < LOAD_READY block; fwd_hit is reported as above.
- Undefined: no forwarding. Any hit in entries 0..DEPTH-2 blocks, fwd_hit is tied to 0, and LOAD_READY is unused.

Test Plan:
- Reset, then idle with advance=1 -> id_ready=1, pending=0, fwd_hit=0; holding resetn=0 for 3 cycles mid-stream clears a non-zero pending to 0.
- FWD_EN, LOAD_READY=1:
  - issue load writing r5 (wmask bit4), next cycle id_rmask=bit4 -> id_ready=0 for 1 cycle; next cycle id_ready=1 and fwd_hit=3'b010.
  - ALU write r5, then a dependent reader -> id_ready=1 and fwd_hit=3'b001.
- No FWD_EN: ALU writes r3, then a dependent reader -> id_ready=0 for 2 cycles, issues on cycle 3 with the entry in slot 2 (WB).
- Shadowing: load r7 issued, then ALU r7, then a reader of r7 -> no stall; fwd_hit=3'b001 only.
- advance=0 for 4 cycles with a load in entry 0 -> pending is unchanged, id_ready=0. Then flush=1 with flush_depth=1 -> entry 0 cleared, pending=0.
- Simultaneous flush and valid issue-eligible instruction with flush_depth=0 -> instruction not inserted; entry 0 becomes a bubble; older entries shift normally.
